// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I-refill and D refill/write-back line bursts
module mem_port_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_wnext,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(4 * BURST_LEN - 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(BURST_LEN);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state;
  logic owner, last, idle, sel_d, grant, fire, rd_beat;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] issue_cnt, ret_cnt;
  always_comb begin
    idle = state == IDLE && !rst && !i_done && !d_done;
    sel_d = d_req && (!i_req || !last);
    grant = idle && (i_req || d_req);
    i_ack = grant && !sel_d;
    d_ack = grant && sel_d;
    mem_valid = state != IDLE && issue_cnt < FULL;
    mem_we = state == WR;
    mem_addr = mem_valid ? base + ADDR_W'({issue_cnt, 2'b00}) : '0;
    mem_wdata = mem_we ? d_wdata : '0;
    fire = mem_valid && mem_ready;
    d_wnext = mem_we && fire;
    rd_beat = state == RD && mem_rvalid;
    i_rvalid = rd_beat && !owner;
    d_rvalid = rd_beat && owner;
    i_rdata = i_rvalid ? mem_rdata : '0;
    d_rdata = d_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b0;
      base <= '0;
      issue_cnt <= '0;
      ret_cnt <= '0;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant) begin
        state <= sel_d && d_we ? WR : RD;
        owner <= sel_d;
        last <= sel_d;
        base <= (sel_d ? d_addr : i_addr) & ~LINE_MASK;
        issue_cnt <= '0;
        ret_cnt <= '0;
      end
      if (fire) issue_cnt <= issue_cnt + CW'(1);
      if (rd_beat) ret_cnt <= ret_cnt + CW'(1);
      if ((rd_beat && ret_cnt == LAST) || (d_wnext && issue_cnt == LAST)) begin
        state <= IDLE;
        i_done <= !owner;
        d_done <= owner;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a line-burst reference model and a memory responder
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, d_we = 0, mem_ready = 0, mem_rvalid = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic i_ack, i_rvalid, i_done, d_ack, d_wnext, d_rvalid, d_done, mem_valid, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [159:0] outs;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_wnext(d_wnext),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  assign outs = {i_ack, i_rvalid, i_rdata, i_done, d_ack, d_wnext, d_rvalid, d_rdata, d_done, mem_valid, mem_we, mem_addr, mem_wdata};
  typedef struct {
    logic [31:0] addr;
    logic we;
    logic [31:0] data;
  } cmd_t;
  cmd_t cmd_q[$];
  cmd_t c;
  logic [31:0] ret_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] hs_log[$];
  bit ack_log[$];
  logic [31:0] dw[4];
  int checks = 0, passed = 0;
  int i_ack_cnt = 0, d_ack_cnt = 0, i_done_cnt = 0, d_done_cnt = 0, i_rv_cnt = 0, wnext_cnt = 0, hs_cnt = 0, widx = 0;
  bit busy = 0, m_last = 0, m_owner = 0, m_we = 0, m_clr = 0, sel_m = 0, w_exp = 0, rv_exp = 0;
  int done_pend = 0;
  logic [1:0] exp_ack;
  logic [31:0] a_m, base_m;
  int ready_mode = 1, gen_mode = 0, rd_ptr = 0;
  int i_ack_used = 0, d_ack_used = 0, i_done_used = 0, d_done_used = 0;
  bit fast = 1, alt = 0, drv_rv = 0, stray_req = 0, i_out = 0, d_out = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cmd_q.delete();
      ret_q.delete();
      busy = 0;
      m_last = 0;
      done_pend = 0;
      widx = 0;
      m_clr = 0;
    end else begin
      if (done_pend != 0 || i_done || d_done) begin
        chk("i_done", i_done, done_pend == 1);
        chk("d_done", d_done, done_pend == 2);
        m_clr = done_pend != 0;
        done_pend = 0;
      end
      i_done_cnt += int'(i_done);
      d_done_cnt += int'(d_done);
      w_exp = mem_valid && mem_ready && cmd_q.size() > 0 && cmd_q[0].we;
      if (d_wnext || w_exp) chk("d_wnext", d_wnext, w_exp);
      if (d_wnext) begin
        wnext_cnt++;
        widx++;
      end
      if (cmd_q.size() > 0) begin
        chk("mem_valid", mem_valid, 1);
        if (mem_valid) begin
          c = cmd_q[0];
          chk("mem_addr", mem_addr, c.addr);
          chk("mem_we", mem_we, c.we);
          if (c.we) chk("mem_wdata", mem_wdata, c.data);
          if (mem_ready) begin
            void'(cmd_q.pop_front());
            hs_cnt++;
            hs_log.push_back(c.we ? mem_wdata : mem_addr);
            if (!c.we) rd_log.push_back(mem_addr);
            else if (cmd_q.size() == 0) done_pend = 2;
          end
        end
      end else if (mem_valid) chk("mem_valid_idle", mem_valid, 0);
      if (mem_rvalid || i_rvalid || d_rvalid) begin
        rv_exp = drv_rv && ret_q.size() > 0;
        chk("i_rvalid", i_rvalid, rv_exp && !m_owner);
        chk("d_rvalid", d_rvalid, rv_exp && m_owner);
        if (rv_exp) begin
          a_m = ret_q.pop_front();
          chk("rdata", m_owner ? d_rdata : i_rdata, mem_f(a_m));
          chk("other_rdata", m_owner ? i_rdata : d_rdata, 0);
          if (ret_q.size() == 0) done_pend = m_owner ? 2 : 1;
        end
      end
      i_rv_cnt += int'(i_rvalid);
      exp_ack = 2'b00;
      if (!busy && (i_req || d_req)) begin
        sel_m = (i_req && d_req) ? !m_last : d_req;
        exp_ack = sel_m ? 2'b01 : 2'b10;
      end
      if (i_ack || d_ack || exp_ack != 0) chk("ack", {i_ack, d_ack}, exp_ack);
      if (i_ack) i_ack_cnt++;
      if (d_ack) begin
        d_ack_cnt++;
        widx = 0;
      end
      if (exp_ack != 0) begin
        m_owner = sel_m;
        m_last = sel_m;
        busy = 1;
        m_we = sel_m && d_we;
        a_m = sel_m ? d_addr : i_addr;
        base_m = a_m - (a_m % 16);
        for (int k = 0; k < 4; k++) begin
          c.addr = base_m + 32'(4 * k);
          c.we = m_we;
          c.data = m_we ? dw[k] : 32'h0;
          cmd_q.push_back(c);
          if (!m_we) ret_q.push_back(c.addr);
        end
        ack_log.push_back(sel_m);
      end
      if (m_clr) busy = 0;
      m_clr = 0;
    end
  end

  task automatic raise_i(input logic [31:0] a);
    i_req = 1;
    i_addr = a;
    i_out = 1;
  endtask

  task automatic raise_d(input logic [31:0] a, input logic we);
    d_req = 1;
    d_addr = a;
    d_we = we;
    d_out = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (i_ack_cnt != i_ack_used) begin
      i_ack_used = i_ack_cnt;
      i_req = 0;
    end
    if (d_ack_cnt != d_ack_used) begin
      d_ack_used = d_ack_cnt;
      d_req = 0;
    end
    if (i_done_cnt != i_done_used) begin
      i_done_used = i_done_cnt;
      i_out = 0;
    end
    if (d_done_cnt != d_done_used) begin
      d_done_used = d_done_cnt;
      d_out = 0;
    end
    if (rst) begin
      i_out = 0;
      d_out = 0;
      rd_ptr = rd_log.size();
    end
    if (gen_mode != 0 && !rst) begin
      if (!i_out && (gen_mode == 2 || $urandom_range(0, 3) == 0)) raise_i($urandom);
      if (!d_out && (gen_mode == 2 || $urandom_range(0, 3) == 0)) begin
        for (int k = 0; k < 4; k++) dw[k] = $urandom;
        raise_d($urandom, gen_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1)));
      end
    end
    d_wdata = dw[widx % 4];
    alt = !alt;
    mem_ready = ready_mode == 0 ? ($urandom_range(0, 3) != 0) : ready_mode == 1 ? 1'b1 : ready_mode == 2 ? alt : 1'b0;
    drv_rv = 0;
    if (!rst && rd_ptr < rd_log.size() && (fast || $urandom_range(0, 2) != 0)) begin
      mem_rdata = mem_f(rd_log[rd_ptr]);
      rd_ptr++;
      drv_rv = 1;
    end else mem_rdata = $urandom;
    mem_rvalid = drv_rv || stray_req;
    stray_req = 0;
  endtask

  function automatic int cnt(input int w);
    return w == 0 ? i_done_cnt : w == 1 ? d_done_cnt : w == 2 ? hs_cnt : i_ack_cnt + d_ack_cnt;
  endfunction

  task automatic wait_cnt(input string name, input int w, input int target);
    for (int t = 0; t < 600 && cnt(w) < target; t++) step();
    chk(name, cnt(w) >= target, 1);
  endtask

  int n, r, nd, a0;
  logic [31:0] held;
  initial begin
    for (int k = 0; k < 4; k++) dw[k] = 0;
    repeat (3) step();
    rst = 0;
    step();
    @(negedge clk);
    chk("reset_outputs", outs, 0);
    n = hs_log.size();
    r = i_rv_cnt;
    nd = i_done_cnt;
    raise_i(32'h0000_104C);
    wait_cnt("b_done_wait", 0, nd + 1);
    repeat (5) step();
    for (int k = 0; k < 4; k++) chk("b_rd_addr", hs_log[n + k], 32'h1040 + 32'(4 * k));
    chk("b_rvalid_beats", i_rv_cnt - r, 4);
    chk("b_done_once", i_done_cnt - nd, 1);
    a0 = ack_log.size();
    n = i_done_cnt;
    nd = d_done_cnt;
    raise_i($urandom);
    raise_d($urandom, 0);
    wait_cnt("c_d_wait", 1, nd + 1);
    wait_cnt("c_i_wait", 0, n + 1);
    repeat (3) step();
    raise_i($urandom);
    raise_d($urandom, 0);
    wait_cnt("c_d_wait2", 1, nd + 2);
    wait_cnt("c_i_wait2", 0, n + 2);
    chk("c_first_d", ack_log[a0], 1);
    chk("c_second_i", ack_log[a0 + 1], 0);
    chk("c_third_d", ack_log[a0 + 2], 1);
    repeat (3) step();
    ready_mode = 2;
    dw[0] = 32'h11;
    dw[1] = 32'h22;
    dw[2] = 32'h33;
    dw[3] = 32'h44;
    n = hs_log.size();
    r = wnext_cnt;
    nd = d_done_cnt;
    raise_d(32'h0000_2000, 1);
    wait_cnt("d_done_wait", 1, nd + 1);
    repeat (5) step();
    for (int k = 0; k < 4; k++) chk("d_wr_data", hs_log[n + k], dw[k]);
    chk("d_wnext_count", wnext_cnt - r, 4);
    chk("d_done_once", d_done_cnt - nd, 1);
    ready_mode = 1;
    n = hs_cnt;
    r = i_rv_cnt;
    nd = i_done_cnt;
    raise_i(32'h0000_3008);
    wait_cnt("stall_start", 2, n + 1);
    ready_mode = 3;
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      if (k == 0) held = mem_addr;
      else chk("stall_addr", mem_addr, held);
      chk("stall_valid", mem_valid, 1);
    end
    ready_mode = 1;
    wait_cnt("stall_done", 0, nd + 1);
    repeat (3) step();
    chk("stall_beats", i_rv_cnt - r, 4);
    ready_mode = 0;
    fast = 0;
    gen_mode = 1;
    repeat (800) step();
    gen_mode = 0;
    for (int t = 0; t < 1000 && (i_out || d_out); t++) step();
    chk("drain", {i_out, d_out}, 0);
    ready_mode = 1;
    fast = 1;
    repeat (3) step();
    n = hs_cnt;
    raise_i($urandom);
    wait_cnt("rst_beat2", 2, n + 2);
    rst = 1;
    i_req = 0;
    step();
    rst = 0;
    stray_req = 1;
    step();
    @(negedge clk);
    chk("post_reset_outputs", outs, 0);
    n = cnt(3);
    nd = d_done_cnt;
    raise_d($urandom, 0);
    wait_cnt("post_reset_ack", 3, n + 1);
    chk("post_reset_d_ack", ack_log[ack_log.size() - 1], 1);
    wait_cnt("post_reset_done", 1, nd + 1);
    rst = 1;
    step();
    rst = 0;
    a0 = ack_log.size();
    n = cnt(3);
    gen_mode = 2;
    wait_cnt("alt_acks", 3, n + 6);
    gen_mode = 0;
    for (int t = 0; t < 300 && (i_out || d_out); t++) step();
    chk("alt_drain", {i_out, d_out}, 0);
    for (int k = 0; k < 6; k++) chk("alt_order", ack_log[a0 + k], k % 2 == 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
